// File: rtl/sram_ring_pointer_manager_pkg.sv
// Purpose: shared SRAM map constants and controller command encodings for the packet store.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package sram_ring_pointer_manager_pkg;

    // Physical map of the two-chip store: 18-bit word address per chip, chip select on top.
    localparam int SRAM_ADDR_WIDTH = 18;
    localparam int SRAM_PTR_WIDTH  = SRAM_ADDR_WIDTH + 1;
    localparam int SRAM_CAPACITY   = (1 << SRAM_PTR_WIDTH) - 1;

    // Command encodings shared with the memory controller and the telemetry packer.
    typedef enum logic [1:0] {
        SRAM_CMD_IDLE  = 2'd0,
        SRAM_CMD_WRITE = 2'd1,
        SRAM_CMD_READ  = 2'd2,
        SRAM_CMD_CLEAR = 2'd3
    } sram_cmd_e;

endpackage

// File: rtl/sram_ring_pointer_manager_rise_detect.sv
// Purpose: turn a controller completion level into a one-cycle pulse on its rising edge.
// Latency: combinational pulse in the sampling cycle; history register updates every cycle.
// Backpressure: none; a level held high yields a single pulse until it drops for a cycle.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic level_q;

    // Remember last cycle's level; cleared by reset so a level high at release counts as an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/sram_ring_pointer_manager.sv
// Purpose: read/write pointers, occupancy and error telemetry for the two-chip SRAM ring buffer.
// Latency: one cycle; a completion edge sampled at edge N is reflected in all outputs after edge N.
// Backpressure: none; full either drops the oldest word or overwrites in place, empty reads flag underflow.
module sram_ring_pointer_manager
    import sram_ring_pointer_manager_pkg::*;
#(
    parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH,
    parameter bit OVERWRITE  = 1'b1,
    parameter int OVF_WIDTH  = 16
) (
    input  logic                  CLK_48MHZ,
    input  logic                  RESET,
    input  logic                  NEXT_WRITE,
    input  logic                  NEXT_READ,
    input  logic                  CLEAR,
    output logic [ADDR_WIDTH-1:0] WRITE_ADDRESS,
    output logic                  WRITE_CHIP_SELECT,
    output logic [ADDR_WIDTH-1:0] READ_ADDRESS,
    output logic                  READ_CHIP_SELECT,
    output logic [ADDR_WIDTH:0]   WORD_COUNT,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic [OVF_WIDTH-1:0]  OVERFLOW_COUNT,
    output logic                  UNDERFLOW
);

    localparam int PW = ADDR_WIDTH + 1;
    // One slot is always kept free so wp == rp means empty only.
    localparam logic [PW-1:0] CAP = '1;

    logic          we;
    logic          re;
    logic [PW-1:0] wp, rp, cnt;
    logic [PW-1:0] wp_n, rp_n, cnt_n;
    logic          empty_q, full_q;
    logic          udf_q, udf_n;
    logic          ovf_inc;
    logic [OVF_WIDTH-1:0] ovf_q;

    rise_detect u_write_edge (
        .clk   (CLK_48MHZ),
        .rst   (RESET),
        .level (NEXT_WRITE),
        .pulse (we)
    );

    rise_detect u_read_edge (
        .clk   (CLK_48MHZ),
        .rst   (RESET),
        .level (NEXT_READ),
        .pulse (re)
    );

    // Priority resolution: clear, paired op, write, write-while-full, read, read-while-empty.
    always_comb begin
        wp_n    = wp;
        rp_n    = rp;
        cnt_n   = cnt;
        udf_n   = udf_q;
        ovf_inc = 1'b0;
        if (CLEAR) begin
            rp_n  = wp;
            cnt_n = '0;
        end else if (we && !full_q) begin
            if (re && !empty_q) begin
                wp_n = wp + PW'(1);
                rp_n = rp + PW'(1);
            end else begin
                // An empty-buffer read alongside this write only raises the sticky flag.
                wp_n  = wp + PW'(1);
                cnt_n = cnt + PW'(1);
                if (re) begin
                    udf_n = 1'b1;
                end
            end
        end else if (we) begin
            ovf_inc = 1'b1;
            if (OVERWRITE) begin
                // Dropping the oldest word already moves rp; a coincident read is absorbed.
                wp_n = wp + PW'(1);
                rp_n = rp + PW'(1);
            end else if (re) begin
                rp_n  = rp + PW'(1);
                cnt_n = cnt - PW'(1);
            end
        end else if (re && !empty_q) begin
            rp_n  = rp + PW'(1);
            cnt_n = cnt - PW'(1);
        end else if (re) begin
            udf_n = 1'b1;
        end
    end

    // Pointer, count and flag registers; flags come from the next-state count so they track WORD_COUNT.
    always_ff @(posedge CLK_48MHZ or posedge RESET) begin
        if (RESET) begin
            wp      <= '0;
            rp      <= '0;
            cnt     <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wp      <= wp_n;
            rp      <= rp_n;
            cnt     <= cnt_n;
            empty_q <= (cnt_n == '0);
            full_q  <= (cnt_n == CAP);
            udf_q   <= udf_n;
        end
    end

    // Saturating count of writes attempted while full; survives CLEAR.
    always_ff @(posedge CLK_48MHZ or posedge RESET) begin
        if (RESET) begin
            ovf_q <= '0;
        end else if (ovf_inc && (ovf_q != '1)) begin
            ovf_q <= ovf_q + OVF_WIDTH'(1);
        end
    end

    assign WRITE_ADDRESS     = wp[ADDR_WIDTH-1:0];
    assign WRITE_CHIP_SELECT = wp[ADDR_WIDTH];
    assign READ_ADDRESS      = rp[ADDR_WIDTH-1:0];
    assign READ_CHIP_SELECT  = rp[ADDR_WIDTH];
    assign WORD_COUNT        = cnt;
    assign EMPTY             = empty_q;
    assign FULL              = full_q;
    assign OVERFLOW_COUNT    = ovf_q;
    assign UNDERFLOW         = udf_q;

endmodule

// File: tb/tb_sram_ring_pointer_manager.sv
// Purpose: directed self-checking bench for the SRAM ring pointer manager.
// Latency: checks sampled 1 time unit after each rising clock edge.
// Backpressure: n/a.
module tb_sram_ring_pointer_manager;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic nw  = 1'b0;
    logic nr  = 1'b0;
    logic clr = 1'b0;

    int checks = 0;
    int errors = 0;

    // Full-size instance (2^19 words, drop-oldest).
    logic [17:0] d0_wa, d0_ra;
    logic        d0_wcs, d0_rcs, d0_empty, d0_full, d0_udf;
    logic [18:0] d0_wc;
    logic [15:0] d0_ovf;

    // Reduced-width instances (16-slot ring, capacity 15) for wrap/full behaviour.
    logic [2:0]  d1_wa, d1_ra, d2_wa, d2_ra;
    logic        d1_wcs, d1_rcs, d1_empty, d1_full, d1_udf;
    logic        d2_wcs, d2_rcs, d2_empty, d2_full, d2_udf;
    logic [3:0]  d1_wc, d2_wc;
    logic [1:0]  d1_ovf;
    logic [15:0] d2_ovf;

    always #10 clk = ~clk;

    sram_ring_pointer_manager dut0 (
        .CLK_48MHZ(clk), .RESET(rst), .NEXT_WRITE(nw), .NEXT_READ(nr), .CLEAR(clr),
        .WRITE_ADDRESS(d0_wa), .WRITE_CHIP_SELECT(d0_wcs),
        .READ_ADDRESS(d0_ra), .READ_CHIP_SELECT(d0_rcs),
        .WORD_COUNT(d0_wc), .EMPTY(d0_empty), .FULL(d0_full),
        .OVERFLOW_COUNT(d0_ovf), .UNDERFLOW(d0_udf)
    );

    sram_ring_pointer_manager #(.ADDR_WIDTH(3), .OVERWRITE(1'b1), .OVF_WIDTH(2)) dut1 (
        .CLK_48MHZ(clk), .RESET(rst), .NEXT_WRITE(nw), .NEXT_READ(nr), .CLEAR(clr),
        .WRITE_ADDRESS(d1_wa), .WRITE_CHIP_SELECT(d1_wcs),
        .READ_ADDRESS(d1_ra), .READ_CHIP_SELECT(d1_rcs),
        .WORD_COUNT(d1_wc), .EMPTY(d1_empty), .FULL(d1_full),
        .OVERFLOW_COUNT(d1_ovf), .UNDERFLOW(d1_udf)
    );

    sram_ring_pointer_manager #(.ADDR_WIDTH(3), .OVERWRITE(1'b0), .OVF_WIDTH(16)) dut2 (
        .CLK_48MHZ(clk), .RESET(rst), .NEXT_WRITE(nw), .NEXT_READ(nr), .CLEAR(clr),
        .WRITE_ADDRESS(d2_wa), .WRITE_CHIP_SELECT(d2_wcs),
        .READ_ADDRESS(d2_ra), .READ_CHIP_SELECT(d2_rcs),
        .WORD_COUNT(d2_wc), .EMPTY(d2_empty), .FULL(d2_full),
        .OVERFLOW_COUNT(d2_ovf), .UNDERFLOW(d2_udf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        nw  = 1'b0;
        nr  = 1'b0;
        clr = 1'b0;
        #1;
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_w();
        nw = 1'b1;
        tick();
        nw = 1'b0;
        tick();
    endtask

    task automatic pulse_r();
        nr = 1'b1;
        tick();
        nr = 1'b0;
        tick();
    endtask

    initial begin
        // Reset values
        do_reset();
        chk("rst_wa", 32'(d0_wa), 0);
        chk("rst_wcs", 32'(d0_wcs), 0);
        chk("rst_ra", 32'(d0_ra), 0);
        chk("rst_rcs", 32'(d0_rcs), 0);
        chk("rst_wc", 32'(d0_wc), 0);
        chk("rst_empty", 32'(d0_empty), 1);
        chk("rst_full", 32'(d0_full), 0);
        chk("rst_ovf", 32'(d0_ovf), 0);
        chk("rst_udf", 32'(d0_udf), 0);

        // 3 writes then 1 read; first write visible right after its sampling edge
        nw = 1'b1;
        tick();
        chk("lat_wa", 32'(d0_wa), 1);
        chk("lat_empty", 32'(d0_empty), 0);
        nw = 1'b0;
        tick();
        pulse_w();
        pulse_w();
        pulse_r();
        chk("basic_wa", 32'(d0_wa), 3);
        chk("basic_ra", 32'(d0_ra), 1);
        chk("basic_wc", 32'(d0_wc), 2);
        chk("basic_empty", 32'(d0_empty), 0);

        // Simultaneous write/read at count 10
        do_reset();
        repeat (10) pulse_w();
        nw = 1'b1;
        nr = 1'b1;
        tick();
        nw = 1'b0;
        nr = 1'b0;
        tick();
        chk("pair_wa", 32'(d0_wa), 11);
        chk("pair_ra", 32'(d0_ra), 1);
        chk("pair_wc", 32'(d0_wc), 10);
        chk("pair_udf", 32'(d0_udf), 0);

        // Simultaneous write/read at count 0
        do_reset();
        nw = 1'b1;
        nr = 1'b1;
        tick();
        nw = 1'b0;
        nr = 1'b0;
        tick();
        chk("pair0_udf", 32'(d0_udf), 1);
        chk("pair0_wa", 32'(d0_wa), 1);
        chk("pair0_ra", 32'(d0_ra), 0);
        chk("pair0_wc", 32'(d0_wc), 1);

        // Underflow set, 5 writes, CLEAR with a coincident write edge
        do_reset();
        pulse_r();
        chk("udf_set", 32'(d0_udf), 1);
        chk("udf_ra", 32'(d0_ra), 0);
        repeat (5) pulse_w();
        clr = 1'b1;
        nw  = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_ra", 32'(d0_ra), 5);
        chk("clr_wa", 32'(d0_wa), 5);
        chk("clr_wc", 32'(d0_wc), 0);
        chk("clr_empty", 32'(d0_empty), 1);
        chk("clr_udf_kept", 32'(d0_udf), 1);
        tick();
        chk("clr_hold_wa", 32'(d0_wa), 5);
        chk("clr_hold_wc", 32'(d0_wc), 0);
        nw = 1'b0;
        tick();

        // Level held high for 20 cycles gives one event
        nw = 1'b1;
        repeat (20) tick();
        chk("hold_wa", 32'(d0_wa), 6);
        chk("hold_wc", 32'(d0_wc), 1);
        nw = 1'b0;
        tick();

        // Asynchronous reset mid-sequence
        nw = 1'b1;
        tick();
        chk("pre_rst_wa", 32'(d0_wa), 7);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_wa", 32'(d0_wa), 0);
        chk("arst_ra", 32'(d0_ra), 0);
        chk("arst_wc", 32'(d0_wc), 0);
        chk("arst_empty", 32'(d0_empty), 1);
        chk("arst_udf", 32'(d0_udf), 0);
        // Level still high at reset release counts as an edge
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rel_edge_wa", 32'(d0_wa), 1);
        nw = 1'b0;
        tick();

        // Small rings: wrap across chips, fill, overflow
        do_reset();
        repeat (7) pulse_w();
        chk("w7_wa", 32'(d1_wa), 7);
        chk("w7_wcs", 32'(d1_wcs), 0);
        pulse_w();
        chk("wrap1_wa", 32'(d1_wa), 0);
        chk("wrap1_wcs", 32'(d1_wcs), 1);
        repeat (6) pulse_w();
        chk("w14_wc", 32'(d1_wc), 14);
        chk("w14_full", 32'(d1_full), 0);
        pulse_w();
        chk("full_flag", 32'(d1_full), 1);
        chk("full_wc", 32'(d1_wc), 15);
        chk("full_wa", 32'(d1_wa), 7);
        chk("full_wcs", 32'(d1_wcs), 1);
        chk("full_ra", 32'(d1_ra), 0);
        chk("full_flag_ow0", 32'(d2_full), 1);
        pulse_w();
        chk("ow1_wa", 32'(d1_wa), 0);
        chk("ow1_wcs", 32'(d1_wcs), 0);
        chk("ow1_ra", 32'(d1_ra), 1);
        chk("ow1_wc", 32'(d1_wc), 15);
        chk("ow1_ovf", 32'(d1_ovf), 1);
        chk("ow0_wa", 32'(d2_wa), 7);
        chk("ow0_wcs", 32'(d2_wcs), 1);
        chk("ow0_ra", 32'(d2_ra), 0);
        chk("ow0_wc", 32'(d2_wc), 15);
        chk("ow0_ovf", 32'(d2_ovf), 1);
        repeat (3) pulse_w();
        chk("ow1_ovf_sat", 32'(d1_ovf), 3);
        chk("ow1_wa3", 32'(d1_wa), 3);
        chk("ow1_ra4", 32'(d1_ra), 4);
        chk("ow0_ovf4", 32'(d2_ovf), 4);

        // Write and read together while full
        nw = 1'b1;
        nr = 1'b1;
        tick();
        nw = 1'b0;
        nr = 1'b0;
        tick();
        chk("owpair1_wa", 32'(d1_wa), 4);
        chk("owpair1_ra", 32'(d1_ra), 5);
        chk("owpair1_wc", 32'(d1_wc), 15);
        chk("owpair1_ovf", 32'(d1_ovf), 3);
        chk("owpair0_wa", 32'(d2_wa), 7);
        chk("owpair0_ra", 32'(d2_ra), 1);
        chk("owpair0_wc", 32'(d2_wc), 14);
        chk("owpair0_full", 32'(d2_full), 0);
        chk("owpair0_ovf", 32'(d2_ovf), 5);

        // Plain read after leaving full
        pulse_r();
        chk("rd1_ra", 32'(d1_ra), 6);
        chk("rd1_wc", 32'(d1_wc), 14);
        chk("rd1_full", 32'(d1_full), 0);
        chk("rd0_ra", 32'(d2_ra), 2);
        chk("rd0_wc", 32'(d2_wc), 13);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
